wbcopy: RTL and testbench
=========================

WBCOPY -- requirements
Module: wbcopy

Interface
REQ-001 Parameter: TIMEOUT, 255, cycles allowed from strobe acceptance to ack before the transfer aborts with error.
REQ-002 Port: clk_i  in  1  sole clock; all state on rising edge.
REQ-003 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-004 Port: start_i  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 Port: src_i  in  32  source byte address; bits [1:0] ignored.
REQ-006 Port: dst_i  in  32  destination byte address; bits [1:0] ignored.
REQ-007 Port: len_i  in  16  number of 32-bit words to copy.
REQ-008 Port: abort_i  in  1  stop after the bus cycle in progress.
REQ-009 Port: busy_o  out  1  high from accepted start until done_o.
REQ-010 Port: done_o  out  1  one-cycle pulse at completion, abort or error.
REQ-011 Port: err_o  out  1  sticky timeout flag; cleared by next accepted start.
REQ-012 Port: bus  if_wb.master  --  pipelined Wishbone master: cyc, stb, we, adr[31:0], sel[3:0], write data, read data, ack, stall.

Function
REQ-013 States SHALL be IDLE, RD, RDW, WR, WRW, FIN.
REQ-014 IDLE + start_i SHALL latch src, dst (bits [1:0] forced 0), len; go to RD, or to FIN if len_i=0 with no bus activity.
REQ-015 start_i outside IDLE SHALL be ignored.
REQ-016 RD: cyc=1, stb=1, we=0, adr=src, sel=4'hf; stb held until a cycle with stall=0, then go to RDW.
REQ-017 RDW: cyc=1, stb=0; on ack capture read data into a 32-bit buffer, then go to WR.
REQ-018 An ack in the same cycle the strobe is accepted SHALL be honoured directly (skip the wait state).
REQ-019 WR: cyc=1, stb=1, we=1, adr=dst, write data=buffer, sel=4'hf; same stall rule; go to WRW.
REQ-020 WRW: on ack, src+=4, dst+=4 (modulo 2^32), count-=1; count=0 or abort pending -> FIN, else RD.
REQ-021 cyc SHALL drop for at least one cycle between words (deassert in the ack cycle).
REQ-022 abort_i SHALL be latched while busy; the current read+write pair completes, then FIN; a read already acked is still written.
REQ-023 Timeout: counter starts at strobe acceptance; if TIMEOUT cycles elapse without ack, drop cyc/stb, set err_o, go to FIN.
REQ-024 FIN: done_o=1 for one cycle, busy_o falls with it, return to IDLE.
REQ-025 Acks arriving while cyc=0 SHALL be ignored.
REQ-026 Throughput against a zero-stall slave with ack two cycles after stb: 6 cycles per word (RD, RDW x2, WR, WRW x2).

Reset
REQ-027 rst_i SHALL immediately force IDLE, cyc=stb=we=0, adr=0, sel=0, write data=0, busy_o=done_o=err_o=0, counters and buffer zero, abort latch cleared.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no done_o pulse.

Structure
REQ-029 Package wbcopy_pkg SHALL hold the state enum and the word-step constant (4).
REQ-030 Single module; no sub-module; timeout counter and address counters inline.

Verification
REQ-031 src=0x1000, dst=0x2000, len=3 against the dual-port memory model -> three words copied, done_o at cycle 18 after start, err_o=0.
REQ-032 len=0 -> done_o one cycle after start, cyc never asserted.
REQ-033 Slave holds stall=1 for 5 cycles on the first read -> stb and adr held stable throughout, copy still correct.
REQ-034 Slave never acks the write, TIMEOUT=8 -> cyc drops after 8 cycles, err_o=1, done_o pulse, next start clears err_o.
REQ-035 abort_i during second read of len=4 -> exactly two words written, dst 0x2008 onward untouched.
REQ-036 rst_i asserted in WRW -> cyc=0 in the same cycle, busy_o=0, no done_o.

Source files
------------

// File: rtl/wbcopy_pkg.sv
// Shared definitions for the wbcopy word-copy engine: FSM encoding and address stepping.
package wbcopy_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StRd   = 3'd1;
  localparam state_t StRdw  = 3'd2;
  localparam state_t StWr   = 3'd3;
  localparam state_t StWrw  = 3'd4;
  localparam state_t StFin  = 3'd5;

  localparam logic [31:0] WordStep = 32'd4;
  localparam logic [31:0] AdrMask  = 32'hffff_fffc;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle with master and slave views.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, stall
  );
endinterface

// File: rtl/wbcopy.sv
// Word-by-word memory copy engine: read one word, write it, repeat, over a pipelined
// Wishbone master port with per-access ack timeout and graceful abort.
module wbcopy
  import wbcopy_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src_i,
  input  logic [31:0] dst_i,
  input  logic [15:0] len_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  if_wb.master        bus
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     data_q, data_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            abort_q, abort_d;
  logic            err_q, err_d;
  logic            word_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    abort_d   = abort_q;
    err_d     = err_q;
    word_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d   = src_i & AdrMask;
          dst_d   = dst_i & AdrMask;
          cnt_d   = len_i;
          err_d   = 1'b0;
          abort_d = 1'b0;
          tmo_d   = '0;
          state_d = (len_i == 16'd0) ? StFin : StRd;
        end
      end
      StRd: begin
        if (!bus.stall) begin
          tmo_d = '0;
          // An ack alongside acceptance completes the read without a wait state.
          if (bus.ack) begin
            data_d  = bus.dat_r;
            state_d = StWr;
          end else begin
            state_d = StRdw;
          end
        end
      end
      StRdw: begin
        if (bus.ack) begin
          data_d  = bus.dat_r;
          state_d = StWr;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWr: begin
        if (!bus.stall) begin
          tmo_d = '0;
          if (bus.ack) begin
            word_done = 1'b1;
          end else begin
            state_d = StWrw;
          end
        end
      end
      StWrw: begin
        if (bus.ack) begin
          word_done = 1'b1;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (word_done) begin
      src_d   = src_q + WordStep;
      dst_d   = dst_q + WordStep;
      cnt_d   = cnt_q - 16'd1;
      state_d = (cnt_q == 16'd1 || abort_q || abort_i) ? StFin : StRd;
    end

    if (busy_o && abort_i) begin
      abort_d = 1'b1;
    end
  end

  assign busy_o = (state_q != StIdle) && (state_q != StFin);
  assign done_o = (state_q == StFin);
  assign err_o  = err_q;

  // cyc falls combinationally in the write-ack cycle so every word is its own bus cycle.
  assign bus.cyc   = (state_q == StRd) || (state_q == StRdw) || (state_q == StWr) ||
                     ((state_q == StWrw) && !bus.ack);
  assign bus.stb   = (state_q == StRd) || (state_q == StWr);
  assign bus.we    = (state_q == StWr);
  assign bus.adr   = (state_q == StRd) ? src_q : ((state_q == StWr) ? dst_q : 32'd0);
  assign bus.sel   = bus.stb ? 4'hf : 4'h0;
  assign bus.dat_w = (state_q == StWr) ? data_q : 32'd0;

endmodule

// File: tb/tb_wbcopy.sv
// Self-checking bench for wbcopy: memory slave model with configurable latency and stall,
// plus a word-level reference copy model.
module tb_wbcopy;

  localparam int unsigned Tmo      = 8;
  localparam int unsigned MemWords = 4096;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;

  if_wb bus ();

  wbcopy #(.TIMEOUT(Tmo)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .src_i   (src),
    .dst_i   (dst),
    .len_i   (len),
    .abort_i (abort),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory model
  logic [31:0] mem     [MemWords];
  logic [31:0] img     [MemWords];
  logic [31:0] exp_mem [MemWords];
  int          lat;
  bit          no_ack_wr;
  bit          rnd_en;
  bit          rnd_bit;
  bit          force_stall;
  bit          stray;
  bit          fill_go;
  logic        pend;
  logic        ack_q;
  int          rem;
  logic        req_we;
  logic [11:0] req_idx;
  logic [31:0] req_dat;
  logic [31:0] rd_q;
  int          wr_count = 0;
  logic        ack0;
  logic        accept;

  int n_cmp = 0;
  int n_bad = 0;

  assign accept    = bus.cyc && bus.stb && !bus.stall;
  assign ack0      = (lat == 0) && bus.stb && !bus.stall;
  assign bus.stall = force_stall || (rnd_en && rnd_bit);
  assign bus.ack   = ack_q || ack0 || stray;
  assign bus.dat_r = (lat == 0) ? mem[bus.adr[13:2]] : rd_q;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      ack_q <= 1'b0;
      rem   <= 0;
    end else begin
      ack_q <= 1'b0;
      if (fill_go) begin
        for (int i = 0; i < MemWords; i++) mem[i] <= $urandom;
      end
      if (lat == 0) begin
        if (ack0 && bus.we) begin
          mem[bus.adr[13:2]] <= bus.dat_w;
          wr_count <= wr_count + 1;
        end
      end else if (pend) begin
        if (rem == 1) begin
          ack_q <= 1'b1;
          pend  <= 1'b0;
          if (req_we) begin
            mem[req_idx] <= req_dat;
            wr_count <= wr_count + 1;
          end else begin
            rd_q <= mem[req_idx];
          end
        end else begin
          rem <= rem - 1;
        end
      end else if (accept && !(no_ack_wr && bus.we)) begin
        if (lat == 1) begin
          ack_q <= 1'b1;
          if (bus.we) begin
            mem[bus.adr[13:2]] <= bus.dat_w;
            wr_count <= wr_count + 1;
          end else begin
            rd_q <= mem[bus.adr[13:2]];
          end
        end else begin
          pend    <= 1'b1;
          rem     <= lat - 1;
          req_we  <= bus.we;
          req_idx <= bus.adr[13:2];
          req_dat <= bus.dat_w;
        end
      end
    end
  end

  task automatic fill_mem();
    @(negedge clk);
    fill_go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fill_go = 1'b0;
    for (int i = 0; i < MemWords; i++) img[i] = mem[i];
  endtask

  // Reference: copy n words one after another from s to d over the initial image.
  task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int n);
    int si;
    int di;
    si = int'(s[13:2]);
    di = int'(d[13:2]);
    for (int i = 0; i < MemWords; i++) exp_mem[i] = img[i];
    for (int i = 0; i < n; i++) begin
      exp_mem[(di + i) % MemWords] = exp_mem[(si + i) % MemWords];
    end
  endtask

  function automatic int mem_diffs();
    int b = 0;
    for (int i = 0; i < MemWords; i++) if (mem[i] !== exp_mem[i]) b++;
    return b;
  endfunction

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          output int edges, output int cyc_low, output bit cyc_seen,
                          output bit busy0);
    @(negedge clk);
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = n;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    edges    = 0;
    cyc_low  = 0;
    cyc_seen = 1'b0;
    busy0    = busy;
    while (done !== 1'b1 && edges < 3000) begin
      if (busy && !bus.cyc) cyc_low++;
      if (bus.cyc) cyc_seen = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 3000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.cyc, bus.stb, bus.we, bus.adr, bus.sel, bus.dat_w} !== 71'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h sel=%h dat_w=%h, required all 0",
               bus.cyc, bus.stb, bus.we, bus.adr, bus.sel, bus.dat_w);
    end
    n_cmp++;
    if ({busy, done, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_status: got busy/done/err=%b%b%b, required 000", busy, done, err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    stray = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stray = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, bus.cyc} !== 3'b000) begin
      n_bad++;
      $display("FAIL stray_ack: got busy/done/cyc=%b%b%b, required 000", busy, done, bus.cyc);
    end
  endtask

  task automatic test_basic();
    int edges;
    int cyc_low;
    bit cyc_seen;
    bit busy0;
    lat = 2;
    fill_mem();
    build_expect(32'h1000, 32'h2000, 3);
    run_copy(32'h1000, 32'h2000, 16'd3, edges, cyc_low, cyc_seen, busy0);
    n_cmp++;
    if (done !== 1'b1 || edges != 18) begin
      n_bad++;
      $display("FAIL basic_done_time: done=%b after %0d edges, required done=1 after 18",
               done, edges);
    end
    n_cmp++;
    if (busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: got %b after start, required 1", busy0);
    end
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_end_status: got busy=%b err=%b, required 0 0", busy, err);
    end
    n_cmp++;
    if (cyc_low != 3) begin
      n_bad++;
      $display("FAIL basic_cyc_gaps: got %0d busy cycles with cyc=0, required 3", cyc_low);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL basic_mem: %0d words differ, required 0", mem_diffs());
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: got done=%b next cycle, required 0", done);
    end
  endtask

  task automatic test_len0();
    int edges;
    int cyc_low;
    bit cyc_seen;
    bit busy0;
    lat = 2;
    fill_mem();
    build_expect(32'h1000, 32'h2000, 0);
    run_copy(32'h1000, 32'h2000, 16'd0, edges, cyc_low, cyc_seen, busy0);
    // edges==0: done is visible in the cycle right after the start cycle.
    n_cmp++;
    if (done !== 1'b1 || edges != 0) begin
      n_bad++;
      $display("FAIL len0_done: done=%b after %0d edges, required done=1 after 0", done, edges);
    end
    n_cmp++;
    if (cyc_seen || bus.cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_no_cyc: got cyc_seen=%b, required 0", cyc_seen);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL len0_mem: %0d words differ, required 0", mem_diffs());
    end
  endtask

  task automatic test_zero_lat();
    int edges;
    int cyc_low;
    bit cyc_seen;
    bit busy0;
    lat = 0;
    fill_mem();
    build_expect(32'h1100, 32'h2100, 3);
    run_copy(32'h1100, 32'h2100, 16'd3, edges, cyc_low, cyc_seen, busy0);
    n_cmp++;
    if (done !== 1'b1 || edges != 6) begin
      n_bad++;
      $display("FAIL zlat_done_time: done=%b after %0d edges, required done=1 after 6",
               done, edges);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL zlat_mem: %0d words differ, required 0", mem_diffs());
    end
    lat = 2;
  endtask

  task automatic test_stall();
    int edges;
    lat = 2;
    fill_mem();
    build_expect(32'h1000, 32'h2000, 3);
    @(negedge clk);
    start       = 1'b1;
    src         = 32'h1000;
    dst         = 32'h2000;
    len         = 16'd3;
    force_stall = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (bus.stb !== 1'b1 || bus.we !== 1'b0 || bus.adr !== 32'h1000) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got stb=%b we=%b adr=%h, required 1 0 00001000",
                 k, bus.stb, bus.we, bus.adr);
      end
      @(posedge clk);
    end
    @(negedge clk);
    force_stall = 1'b0;
    wait_done(edges);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_done: got done=%b err=%b, required 1 0", done, err);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL stall_mem: %0d words differ, required 0", mem_diffs());
    end
  endtask

  task automatic test_abort();
    int edges;
    int wr0;
    int n;
    bit seen;
    lat = 2;
    fill_mem();
    build_expect(32'h1000, 32'h2000, 2);
    wr0 = wr_count;
    @(negedge clk);
    start = 1'b1;
    src   = 32'h1000;
    dst   = 32'h2000;
    len   = 16'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    n     = 0;
    while (!seen && n < 100) begin
      if (bus.stb === 1'b1 && bus.we === 1'b0 && bus.adr === 32'h1004) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    wait_done(edges);
    n_cmp++;
    if (!seen || done !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_flow: second read seen=%b done=%b, required 1 1", seen, done);
    end
    n_cmp++;
    if (wr_count - wr0 != 2) begin
      n_bad++;
      $display("FAIL abort_writes: got %0d writes, required 2", wr_count - wr0);
    end
    n_cmp++;
    if (mem_diffs() != 0) begin
      n_bad++;
      $display("FAIL abort_mem: %0d words differ, required 0", mem_diffs());
    end
  endtask

  task automatic test_timeout();
    int  high;
    int  n;
    int  edges;
    lat       = 2;
    no_ack_wr = 1'b1;
    fill_mem();
    @(negedge clk);
    start = 1'b1;
    src   = 32'h1000;
    dst   = 32'h2000;
    len   = 16'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (!(bus.stb === 1'b1 && bus.we === 1'b1) && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    high = 0;
    while (bus.cyc === 1'b1 && high < 100) begin
      high++;
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (high != Tmo) begin
      n_bad++;
      $display("FAIL tmo_cyc_len: cyc held %0d cycles after acceptance, required %0d",
               high, Tmo);
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_done_err: got done=%b err=%b, required 1 1", done, err);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_sticky: got err=%b done=%b, required 1 0", err, done);
    end
    no_ack_wr = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_err_clear: got err=%b after new start, required 0", err);
    end
    wait_done(edges);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_recover: got done=%b err=%b, required 1 0", done, err);
    end
  endtask

  task automatic test_random();
    int          edges;
    int          cyc_low;
    bit          cyc_seen;
    bit          busy0;
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] n;
    rnd_en = 1'b1;
    for (int it = 0; it < 8; it++) begin
      lat = int'($urandom_range(1, 3));
      s   = 32'($urandom_range(0, 32'h2fff));
      d   = 32'($urandom_range(0, 32'h2fff));
      n   = 16'($urandom_range(1, 8));
      fill_mem();
      build_expect(s, d, int'(n));
      run_copy(s, d, n, edges, cyc_low, cyc_seen, busy0);
      n_cmp++;
      if (done !== 1'b1 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL rand[%0d]_done: got done=%b err=%b, required 1 0", it, done, err);
      end
      n_cmp++;
      if (mem_diffs() != 0) begin
        n_bad++;
        $display("FAIL rand[%0d]_mem: src=%h dst=%h len=%0d lat=%0d, %0d words differ, required 0",
                 it, s, d, n, lat, mem_diffs());
      end
    end
    rnd_en = 1'b0;
    lat    = 2;
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen_done;
    lat = 2;
    fill_mem();
    @(negedge clk);
    start = 1'b1;
    src   = 32'h1000;
    dst   = 32'h2000;
    len   = 16'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (!(bus.stb === 1'b1 && bus.we === 1'b1) && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.cyc !== 1'b1 || bus.stb !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre: got cyc=%b stb=%b busy=%b, required 1 0 1",
               bus.cyc, bus.stb, busy);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.cyc, bus.stb, busy, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rstmid_now: got cyc/stb/busy/done=%b%b%b%b, required 0000",
               bus.cyc, bus.stb, busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (seen_done) begin
      n_bad++;
      $display("FAIL rstmid_quiet: done or busy seen after reset, required none");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start       = 1'b0;
    src         = '0;
    dst         = '0;
    len         = '0;
    abort       = 1'b0;
    lat         = 2;
    no_ack_wr   = 1'b0;
    rnd_en      = 1'b0;
    force_stall = 1'b0;
    stray       = 1'b0;
    fill_go     = 1'b0;
    test_reset();
    test_stray_ack();
    test_basic();
    test_len0();
    test_zero_lat();
    test_stall();
    test_abort();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
